lcd_spi_stream_tx: RTL and testbench

- Parametrised successor to the single-byte ST7735S-style SPI LCD transmitter.
- Buffers command/data words in an internal FIFO. Sends 8-bit or 16-bit words, MSB first, with D/C per word.
- Keeps chip-select low across back-to-back words so pixel streams go out in one burst.
- Sits between the display controller FSM / framebuffer reader and the LCD pins.

---
 rtl/lcd_spi_pkg.sv | 31 +++
 rtl/lcd_spi_fifo.sv | 70 +++++++
 rtl/lcd_spi_stream_tx.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_spi_stream_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_pkg
// Brief    : Shared types and constants for the streaming SPI LCD transmitter
//            (FSM state encoding, FIFO entry layout, word lengths).
// Revision : 1.0 - initial release
// ============================================================================
package lcd_spi_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // FIFO entry layout: {ncommand, wide, data[15:0]}
    localparam int c_ENTRY_W      = 18;
    localparam int c_IDX_NCMD     = 17;
    localparam int c_IDX_WIDE     = 16;
    localparam int c_IDX_DATA_MSB = 15;
    localparam int c_IDX_DATA_LSB = 0;

    // Word lengths in bits, sized to the bit counter
    localparam logic [4:0] c_BITS_NARROW = 5'd8;
    localparam logic [4:0] c_BITS_WIDE   = 5'd16;

endpackage : lcd_spi_pkg
`default_nettype wire

// File: rtl/lcd_spi_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_fifo
// Brief    : Synchronous FIFO, power-of-two DEPTH, registered full/empty/level.
//            A push while full is dropped even if a pop happens the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_FULL_LEVEL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (count_q == c_FULL_LEVEL);
    assign o_empty   = (count_q == '0);
    assign o_level   = count_q;
    assign o_rdata   = mem_q[rd_ptr_q];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : lcd_spi_fifo
`default_nettype wire

// File: rtl/lcd_spi_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_stream_tx
// Brief    : FIFO-buffered SPI transmitter for ST7735S-style LCDs. Sends 8- or
//            16-bit words MSB first with per-word D/C, keeping SS low across
//            back-to-back words.
//            Optional macro LCD_SPI_OVERFLOW_FLAG_EN adds a sticky o_overflow.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_stream_tx
    import lcd_spi_pkg::*;
#(
    parameter int c_CLOCK_PER_SPI_HALF_BIT = 50,
    parameter int c_FIFO_DEPTH             = 16,
    parameter bit c_CPOL                   = 1'b0,
    parameter int c_SS_GAP_CYCLES          = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_ncommand,
    input  logic                              i_wide,
    input  logic [15:0]                       i_data,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic [$clog2(c_FIFO_DEPTH):0]     o_fifo_level,
    output logic                              o_waiting,
    output logic                              o_spi_clk,
    output logic                              o_spi_mosi,
    output logic                              o_spi_dc,
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
    output logic                              o_overflow,
`endif
    output logic                              o_spi_ss
);

    localparam int c_CNT_MAX = (c_CLOCK_PER_SPI_HALF_BIT > c_SS_GAP_CYCLES) ?
                               c_CLOCK_PER_SPI_HALF_BIT : c_SS_GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_CLOCK_PER_SPI_HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(c_SS_GAP_CYCLES - 1);

    logic [c_ENTRY_W-1:0] w_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push_acc;

    state_e               state_q,   state_d;
    logic [c_CNT_W-1:0]   cnt_q,     cnt_d;
    logic                 half_q,    half_d;
    logic [4:0]           bits_q,    bits_d;
    logic [15:0]          sr_q,      sr_d;
    logic                 sck_q,     sck_d;
    logic                 dc_q,      dc_d;
    logic                 ss_q,      ss_d;
    logic                 waiting_q, waiting_d;

    assign w_push_acc   = i_data_valid & ~w_full;
    assign o_data_ready = ~w_full;
    assign o_waiting    = waiting_q;
    assign o_spi_clk    = sck_q;
    assign o_spi_mosi   = sr_q[15];
    assign o_spi_dc     = dc_q;
    assign o_spi_ss     = ss_q;

    lcd_spi_fifo #(
        .DEPTH (c_FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_data_valid),
        .i_wdata ({i_ncommand, i_wide, i_data}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // State and datapath registers; reset aborts any word in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= 1'b0;
            bits_q    <= '0;
            sr_q      <= '0;
            sck_q     <= c_CPOL;
            dc_q      <= 1'b0;
            ss_q      <= 1'b1;
            waiting_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            bits_q    <= bits_d;
            sr_q      <= sr_d;
            sck_q     <= sck_d;
            dc_q      <= dc_d;
            ss_q      <= ss_d;
            waiting_q <= waiting_d;
        end
    end

    // Next-state logic: load, shift bits half by half, hold SS, then gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        bits_d  = bits_q;
        sr_d    = sr_q;
        sck_d   = sck_q;
        dc_d    = dc_q;
        ss_d    = ss_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Narrow words are left-justified so MOSI always comes from bit 15
                w_pop  = 1'b1;
                sr_d   = w_rdata[c_IDX_WIDE] ? w_rdata[c_IDX_DATA_MSB:c_IDX_DATA_LSB]
                                             : {w_rdata[c_IDX_DATA_LSB+7:c_IDX_DATA_LSB], 8'h00};
                bits_d  = w_rdata[c_IDX_WIDE] ? c_BITS_WIDE : c_BITS_NARROW;
                dc_d    = w_rdata[c_IDX_NCMD];
                ss_d    = 1'b0;
                sck_d   = c_CPOL;
                cnt_d   = '0;
                half_d  = 1'b0;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sck_d  = ~c_CPOL;
                    end else begin
                        half_d = 1'b0;
                        sck_d  = c_CPOL;
                        sr_d   = {sr_q[14:0], 1'b0};
                        bits_d = bits_q - 1'b1;
                        if (bits_q == 5'd1) begin
                            state_d = w_empty ? ST_HOLD : ST_LOAD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d   = '0;
                    dc_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Idle indication tracks the FIFO contents as they will be next cycle
        waiting_d = (state_d == ST_IDLE) && w_empty && !w_push_acc;
    end

`ifdef LCD_SPI_OVERFLOW_FLAG_EN
    logic overflow_q;

    assign o_overflow = overflow_q;

    // Sticky record of any push attempted while the FIFO was full
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (i_data_valid && w_full) begin
            overflow_q <= 1'b1;
        end
    end
`endif

endmodule : lcd_spi_stream_tx
`default_nettype wire

// File: tb/tb_lcd_spi_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_stream_tx
// Brief    : Self-checking bench for lcd_spi_stream_tx: table of single words
//            plus directed burst / full / reset / CPOL=1 / gap sequences.
//            Honours LCD_SPI_OVERFLOW_FLAG_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_stream_tx;

    localparam int H0   = 4;
    localparam int GAP0 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ncmd0 = 1'b0, wide0 = 1'b0, valid0 = 1'b0;
    logic [15:0] data0 = '0;
    logic        ready0, waiting0, sck0, mosi0, dc0, ss0;
    logic [4:0]  level0;

    logic        ncmd1 = 1'b0, wide1 = 1'b0, valid1 = 1'b0;
    logic [15:0] data1 = '0;
    logic        ready1, waiting1, sck1, mosi1, dc1, ss1;
    logic [4:0]  level1;
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
    logic        ovf0, ovf1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lcd_spi_stream_tx #(
        .c_CLOCK_PER_SPI_HALF_BIT (H0),
        .c_FIFO_DEPTH             (16),
        .c_CPOL                   (1'b0),
        .c_SS_GAP_CYCLES          (GAP0)
    ) dut0 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ncommand   (ncmd0),
        .i_wide       (wide0),
        .i_data       (data0),
        .i_data_valid (valid0),
        .o_data_ready (ready0),
        .o_fifo_level (level0),
        .o_waiting    (waiting0),
        .o_spi_clk    (sck0),
        .o_spi_mosi   (mosi0),
        .o_spi_dc     (dc0),
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
        .o_overflow   (ovf0),
`endif
        .o_spi_ss     (ss0)
    );

    lcd_spi_stream_tx #(
        .c_CLOCK_PER_SPI_HALF_BIT (2),
        .c_FIFO_DEPTH             (16),
        .c_CPOL                   (1'b1),
        .c_SS_GAP_CYCLES          (4)
    ) dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ncommand   (ncmd1),
        .i_wide       (wide1),
        .i_data       (data1),
        .i_data_valid (valid1),
        .o_data_ready (ready1),
        .o_fifo_level (level1),
        .o_waiting    (waiting1),
        .o_spi_clk    (sck1),
        .o_spi_mosi   (mosi1),
        .o_spi_dc     (dc1),
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
        .o_overflow   (ovf1),
`endif
        .o_spi_ss     (ss1)
    );

    // SPI slave models: sample MOSI/DC on the first SCK edge of each bit
    bit rx0_bits[$];
    bit rx0_dc[$];
    bit rx1_bits[$];
    logic sck0_prev = 1'b0, sck1_prev = 1'b1, ss0_prev = 1'b1;
    int   ss_rises0 = 0;
    int   hi_run    = 0;
    int   last_run  = 0;

    always @(negedge clk) begin
        if (ss0 === 1'b0 && sck0 === 1'b1 && sck0_prev === 1'b0) begin
            rx0_bits.push_back(mosi0);
            rx0_dc.push_back(dc0);
        end
        if (ss1 === 1'b0 && sck1 === 1'b0 && sck1_prev === 1'b1) begin
            rx1_bits.push_back(mosi1);
        end
        if (ss0 === 1'b1 && ss0_prev === 1'b0) ss_rises0 <= ss_rises0 + 1;
        if (ss0 === 1'b1) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run > 0) last_run <= hi_run;
            hi_run <= 0;
        end
        sck0_prev <= sck0;
        sck1_prev <= sck1;
        ss0_prev  <= ss0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // which: 0 = waiting0, 1 = waiting1, 2 = ss0
    task automatic wait_for(input int which, input logic val, input int budget, input string name);
        int   n;
        logic s;
        n = 0;
        forever begin
            case (which)
                0:       s = waiting0;
                1:       s = waiting1;
                default: s = ss0;
            endcase
            if (s === val || n >= budget) break;
            @(negedge clk);
            n++;
        end
        if (s !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got %b required %b", name, n, s, val);
        end
    endtask

    task automatic push0(input logic nc, input logic w, input logic [15:0] d);
        ncmd0  = nc;
        wide0  = w;
        data0  = d;
        valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    task automatic take_word(input int n, output logic [15:0] w, output int dc_ones);
        w       = '0;
        dc_ones = 0;
        for (int i = 0; i < n; i++) begin
            if (rx0_bits.size() > 0) begin
                w = {w[14:0], rx0_bits.pop_front()};
                dc_ones += int'(rx0_dc.pop_front());
            end
        end
    endtask

    task automatic clear_rx();
        rx0_bits.delete();
        rx0_dc.delete();
        rx1_bits.delete();
    endtask

    typedef struct {
        logic        ncmd;
        logic        wide;
        logic [15:0] data;
        logic [15:0] exp_word;
        logic        exp_dc;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] w;
        int          dco;
        int          base;
        bit          ok;

        vecs[0] = '{1'b0, 1'b0, 16'h0095, 16'h0095, 1'b0, 8};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0034, 1'b1, 8};
        vecs[2] = '{1'b1, 1'b1, 16'hF800, 16'hF800, 1'b1, 16};
        vecs[3] = '{1'b0, 1'b1, 16'h8001, 16'h8001, 1'b0, 16};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h00FF, 1'b1, 8};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ss",      32'(ss0),      32'd1);
        check("rst_sck",     32'(sck0),     32'd0);
        check("rst_mosi",    32'(mosi0),    32'd0);
        check("rst_dc",      32'(dc0),      32'd0);
        check("rst_waiting", 32'(waiting0), 32'd1);
        check("rst_ready",   32'(ready0),   32'd1);
        check("rst_level",   32'(level0),   32'd0);
        check("rst_sck_cpol1", 32'(sck1),   32'd1);
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
        check("rst_overflow", 32'(ovf0),    32'd0);
`endif

        // Single command with latency: push accepted at edge N, SS falls at N+2
        clear_rx();
        base   = ss_rises0;
        ncmd0  = 1'b0; wide0 = 1'b0; data0 = 16'h0095; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        check("lat_level_n",   32'(level0),   32'd1);
        check("lat_waiting_n", 32'(waiting0), 32'd0);
        check("lat_ss_n",      32'(ss0),      32'd1);
        @(negedge clk);
        check("lat_ss_n1",     32'(ss0),      32'd1);
        @(negedge clk);
        check("lat_ss_n2",     32'(ss0),      32'd0);
        check("lat_mosi_msb",  32'(mosi0),    32'd1);
        check("lat_level_n2",  32'(level0),   32'd0);
        wait_for(0, 1'b1, 1000, "single_done");
        check("single_len",  32'(rx0_bits.size()), 32'd8);
        take_word(8, w, dco);
        check("single_word", 32'(w),   32'h95);
        check("single_dc",   32'(dco), 32'd0);
        check("single_ss_rises", 32'(ss_rises0 - base), 32'd1);

        // Table of single words
        for (int i = 0; i < 5; i++) begin
            clear_rx();
            base = ss_rises0;
            push0(vecs[i].ncmd, vecs[i].wide, vecs[i].data);
            wait_for(0, 1'b1, 2000, $sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_len", i), 32'(rx0_bits.size()), 32'(vecs[i].exp_len));
            take_word(vecs[i].exp_len, w, dco);
            check($sformatf("vec%0d_word", i), 32'(w), 32'(vecs[i].exp_word));
            check($sformatf("vec%0d_dc", i), 32'(dco), vecs[i].exp_dc ? 32'(vecs[i].exp_len) : 32'd0);
            check($sformatf("vec%0d_ss_rises", i), 32'(ss_rises0 - base), 32'd1);
        end

        // Burst: one command and two wide data words in a single SS window
        clear_rx();
        base = ss_rises0;
        push0(1'b0, 1'b0, 16'h002C);
        push0(1'b1, 1'b1, 16'hF800);
        push0(1'b1, 1'b1, 16'h07E0);
        wait_for(0, 1'b1, 3000, "burst_done");
        check("burst_len", 32'(rx0_bits.size()), 32'd40);
        take_word(8, w, dco);
        check("burst_w0", 32'(w), 32'h2C);
        check("burst_dc0", 32'(dco), 32'd0);
        take_word(16, w, dco);
        check("burst_w1", 32'(w), 32'hF800);
        check("burst_dc1", 32'(dco), 32'd16);
        take_word(16, w, dco);
        check("burst_w2", 32'(w), 32'h07E0);
        check("burst_dc2", 32'(dco), 32'd16);
        check("burst_ss_rises", 32'(ss_rises0 - base), 32'd1);

        // Full FIFO: 17 pushes while the SPI is busy, the 17th is dropped
        clear_rx();
        push0(1'b1, 1'b0, 16'h00AA);
        wait_for(2, 1'b0, 100, "full_start");
        for (int k = 0; k < 17; k++) begin
            push0(1'b1, 1'b0, (k < 16) ? 16'(16'h0010 + k) : 16'h00EE);
        end
        check("full_level", 32'(level0), 32'd16);
        check("full_ready", 32'(ready0), 32'd0);
`ifdef LCD_SPI_OVERFLOW_FLAG_EN
        check("full_overflow", 32'(ovf0), 32'd1);
`endif
        wait_for(0, 1'b1, 5000, "full_drain");
        check("full_len", 32'(rx0_bits.size()), 32'd136);
        ok = 1'b1;
        for (int k = 0; k < 17; k++) begin
            take_word(8, w, dco);
            if (w !== ((k == 0) ? 16'h00AA : 16'(16'h000F + k))) ok = 1'b0;
        end
        check("full_words", 32'(ok), 32'd1);

        // Reset mid-word aborts immediately, next word is clean
        clear_rx();
        push0(1'b1, 1'b0, 16'h00A5);
        for (int n = 0; n < 500 && rx0_bits.size() < 4; n++) @(negedge clk);
        check("midrst_bits_seen", 32'(rx0_bits.size()), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ss",      32'(ss0),      32'd1);
        check("midrst_sck",     32'(sck0),     32'd0);
        check("midrst_level",   32'(level0),   32'd0);
        check("midrst_waiting", 32'(waiting0), 32'd1);
        @(negedge clk);
        clear_rx();
        push0(1'b1, 1'b0, 16'h003A);
        wait_for(0, 1'b1, 2000, "midrst_next_done");
        check("midrst_next_len", 32'(rx0_bits.size()), 32'd8);
        take_word(8, w, dco);
        check("midrst_next_word", 32'(w), 32'h3A);

        // CPOL=1 instance: SCK idles high, samples on falling edges
        clear_rx();
        ncmd1 = 1'b1; wide1 = 1'b0; data1 = 16'h0036; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        wait_for(1, 1'b1, 1000, "cpol1_done");
        check("cpol1_len", 32'(rx1_bits.size()), 32'd8);
        w = '0;
        while (rx1_bits.size() > 0) w = {w[14:0], rx1_bits.pop_front()};
        check("cpol1_word", 32'(w), 32'h36);
        check("cpol1_sck_idle", 32'(sck1), 32'd1);

        // Gap timing: second word queued as soon as the first burst ends
        clear_rx();
        base = ss_rises0;
        push0(1'b1, 1'b0, 16'h0011);
        wait_for(2, 1'b0, 100, "gap_ss_low");
        wait_for(2, 1'b1, 1000, "gap_ss_high");
        push0(1'b1, 1'b0, 16'h0011);
        wait_for(0, 1'b1, 2000, "gap_done");
        check("gap_min_high", 32'(last_run >= GAP0), 32'd1);
        check("gap_ss_rises", 32'(ss_rises0 - base), 32'd2);
        check("gap_len", 32'(rx0_bits.size()), 32'd16);
        take_word(8, w, dco);
        check("gap_w0", 32'(w), 32'h11);
        take_word(8, w, dco);
        check("gap_w1", 32'(w), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lcd_spi_stream_tx
`default_nettype wire
